// File: rtl/byte_lane_pkg.sv
// Shared lane definitions for the byte-pair packer and its holding register.
// Packs bytes into 16-bit words with a 2-bit byte-lane enable.
package byte_lane_pkg;

    localparam logic [1:0] BYTEENA_NONE = 2'b00;
    localparam logic [1:0] BYTEENA_LO   = 2'b01;
    localparam logic [1:0] BYTEENA_HI   = 2'b10;
    localparam logic [1:0] BYTEENA_ALL  = 2'b11;

    // EMPTY: no byte held; HALF: first byte of a pair is waiting for its partner
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HALF  = 1'b1
    } packer_state_t;

    typedef struct packed {
        logic [15:0] d;
        logic [1:0]  byteena;
    } lane_word_t;

    // Full word: the first byte of the pair lands in the "first" lane
    function automatic lane_word_t pack_pair(input logic [7:0] first,
                                             input logic [7:0] second,
                                             input logic       lo_first);
        lane_word_t w;
        w.byteena = BYTEENA_ALL;
        w.d       = lo_first ? {second, first} : {first, second};
        return w;
    endfunction

    // Partial word: a lone byte in the first lane, other lane zeroed and disabled
    function automatic lane_word_t pack_single(input logic [7:0] b,
                                               input logic       lo_first);
        lane_word_t w;
        w.byteena = lo_first ? BYTEENA_LO : BYTEENA_HI;
        w.d       = lo_first ? {8'h00, b} : {b, 8'h00};
        return w;
    endfunction

endpackage

// File: rtl/byte_pair_packer_idle_timer.sv
// Saturating idle counter used to flush a lone held byte.
// hit stays high once LIMIT-1 is reached until cleared; LIMIT=0 never hits.
module idle_timer #(
    parameter int LIMIT = 16,
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int              LIM_M1 = (LIMIT > 0) ? LIMIT - 1 : 0;
    localparam logic [CNT_W-1:0] TOP   = CNT_W'(LIM_M1);

    logic [CNT_W-1:0] count;

    // Count idle cycles, stopping at TOP so a blocked flush keeps its hit
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != TOP)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign hit = (LIMIT > 0) && (count == TOP);

endmodule

// File: rtl/byte_pair_packer.sv
// Byte-pair packer: valid/ready byte stream in, 16-bit word + byte enables out.
// Lone trailing bytes are flushed on in_last or after an idle timeout.
module byte_pair_packer
    import byte_lane_pkg::*;
#(
    parameter int LO_FIRST    = 1,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_d,
    output logic [1:0]  out_byteena,
    output logic        pending
);

    localparam logic LO_SEL = (LO_FIRST != 0);

    packer_state_t state;
    packer_state_t next_state;
    logic [7:0]    hold_byte;
    logic          hold_load;
    logic          load;
    logic          flush;
    lane_word_t    load_word;
    logic          in_acc;
    logic          out_acc;
    logic          timer_clear;
    logic          timer_enable;
    logic          timer_hit;

    // A new word may only be loaded when the output register is free or being drained
    assign in_ready = !out_valid || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;
    assign pending  = (state == ST_HALF);

    assign timer_clear  = in_acc || (state == ST_EMPTY) || flush;
    assign timer_enable = (state == ST_HALF) && !in_acc;

    idle_timer #(
        .LIMIT (TIMEOUT_CYC),
        .CNT_W (CNT_W)
    ) u_idle_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .hit    (timer_hit)
    );

    // Decide pairing, last-flush and timeout-flush; pairing takes priority over timeout
    always_comb begin
        next_state = state;
        hold_load  = 1'b0;
        load       = 1'b0;
        flush      = 1'b0;
        load_word  = '0;
        case (state)
            ST_EMPTY: begin
                if (in_acc) begin
                    if (in_last) begin
                        load      = 1'b1;
                        load_word = pack_single(in_data, LO_SEL);
                    end else begin
                        hold_load  = 1'b1;
                        next_state = ST_HALF;
                    end
                end
            end
            ST_HALF: begin
                if (in_acc) begin
                    load       = 1'b1;
                    load_word  = pack_pair(hold_byte, in_data, LO_SEL);
                    next_state = ST_EMPTY;
                end else if (timer_hit && in_ready) begin
                    load       = 1'b1;
                    flush      = 1'b1;
                    load_word  = pack_single(hold_byte, LO_SEL);
                    next_state = ST_EMPTY;
                end
            end
            default: begin
                next_state = ST_EMPTY;
            end
        endcase
    end

    // Packer state register; reset discards any half-built pair
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Capture the first byte of a pair while it waits for its partner
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_byte <= 8'h00;
        end else if (hold_load) begin
            hold_byte <= in_data;
        end
    end

    // Output register: load wins over drain so back-to-back words have no bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_d       <= 16'h0000;
            out_byteena <= BYTEENA_NONE;
        end else if (load) begin
            out_valid   <= 1'b1;
            out_d       <= load_word.d;
            out_byteena <= load_word.byteena;
        end else if (out_acc) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_pair_packer.sv
// Scoreboard bench: two packers (LO_FIRST=1 and LO_FIRST=0) share one input stream.
// Directed stimulus pushes hand-computed words; a negedge monitor pops and compares.
module tb_byte_pair_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, pending_a;
    logic [15:0] out_d_a;
    logic [1:0]  out_byteena_a;
    logic        in_ready_b, out_valid_b, pending_b;
    logic [15:0] out_d_b;
    logic [1:0]  out_byteena_b;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  be;
        int          cyc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    byte_pair_packer #(.LO_FIRST(1), .TIMEOUT_CYC(16), .CNT_W(5)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_d(out_d_a), .out_byteena(out_byteena_a),
        .pending(pending_a)
    );

    byte_pair_packer #(.LO_FIRST(0), .TIMEOUT_CYC(16), .CNT_W(5)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_d(out_d_b), .out_byteena(out_byteena_b),
        .pending(pending_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [15:0] actual,
                                input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic check_cycle(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: output at cycle %0d, want cycle %0d", name, actual, expected);
        end
    endtask

    task automatic expect_word(input logic [15:0] da, input logic [1:0] ba,
                               input logic [15:0] db, input logic [1:0] bb,
                               input int c);
        exp_t e;
        e.d = da; e.be = ba; e.cyc = c;
        q_a.push_back(e);
        e.d = db; e.be = bb;
        q_b.push_back(e);
    endtask

    // Present one byte and hold it until accepted; returns the accepting cycle
    task automatic apply_stimulus(input logic [7:0] b, input logic last, output int acc_cyc);
        logic took;
        int   n;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = last;
        took     = 1'b0;
        n        = 0;
        acc_cyc  = -1;
        while (!took && n < 200) begin
            @(negedge clk);
            took = in_ready_a;
            @(posedge clk);
            #1;
            n++;
        end
        if (took) begin
            acc_cyc = cyc;
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: byte %h not accepted, want accepted", b);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pop and compare each word the consumer takes
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid_a && out_ready) begin
            check_output("byteena_nonzero_a", 16'(out_byteena_a != 2'b00), 16'd1);
            if (q_a.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_a: got %h/%b, want no word", out_d_a, out_byteena_a);
            end else begin
                e = q_a.pop_front();
                check_output("word_d_a", out_d_a, e.d);
                check_output("word_be_a", 16'(out_byteena_a), 16'(e.be));
                if (e.cyc >= 0) check_cycle("latency_a", cyc, e.cyc);
            end
        end
        if (!reset && out_valid_b && out_ready) begin
            if (q_b.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_b: got %h/%b, want no word", out_d_b, out_byteena_b);
            end else begin
                e = q_b.pop_front();
                check_output("word_d_b", out_d_b, e.d);
                check_output("word_be_b", 16'(out_byteena_b), 16'(e.be));
                if (e.cyc >= 0) check_cycle("latency_b", cyc, e.cyc);
            end
        end
    end

    initial begin
        int c;
        int c0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_out_valid", 16'(out_valid_a), 16'd0);
        check_output("rst_out_d", out_d_a, 16'h0000);
        check_output("rst_byteena", 16'(out_byteena_a), 16'd0);
        check_output("rst_pending", 16'(pending_a), 16'd0);
        check_output("rst_in_ready", 16'(in_ready_a), 16'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset mid-pair discards the held byte
        apply_stimulus(8'hA5, 1'b0, c);
        check_output("mid_pair_pending", 16'(pending_a), 16'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_output("post_rst_pending_a", 16'(pending_a), 16'd0);
        check_output("post_rst_pending_b", 16'(pending_b), 16'd0);
        check_output("post_rst_out_valid", 16'(out_valid_a), 16'd0);
        apply_stimulus(8'h01, 1'b0, c);
        apply_stimulus(8'h02, 1'b0, c);
        expect_word(16'h0201, 2'b11, 16'h0102, 2'b11, c);

        // Streaming at full rate
        apply_stimulus(8'h11, 1'b0, c);
        apply_stimulus(8'h22, 1'b0, c);
        expect_word(16'h2211, 2'b11, 16'h1122, 2'b11, c);
        apply_stimulus(8'h33, 1'b0, c);
        apply_stimulus(8'h44, 1'b0, c);
        expect_word(16'h4433, 2'b11, 16'h3344, 2'b11, c);
        apply_stimulus(8'h55, 1'b0, c);
        apply_stimulus(8'h66, 1'b0, c);
        expect_word(16'h6655, 2'b11, 16'h5566, 2'b11, c);

        // in_last partial word
        apply_stimulus(8'hAA, 1'b0, c);
        apply_stimulus(8'hBB, 1'b0, c);
        expect_word(16'hBBAA, 2'b11, 16'hAABB, 2'b11, c);
        apply_stimulus(8'hCC, 1'b1, c);
        expect_word(16'h00CC, 2'b01, 16'hCC00, 2'b10, c);
        idle(2);
        check_output("last_pending", 16'(pending_a), 16'd0);

        // Timeout flush of a lone byte
        apply_stimulus(8'h7E, 1'b0, c0);
        expect_word(16'h007E, 2'b01, 16'h7E00, 2'b10, c0 + 16);
        idle(20);
        check_output("timeout_pending", 16'(pending_a), 16'd0);

        // Partner arriving exactly at the timeout cycle wins
        apply_stimulus(8'h7E, 1'b0, c0);
        idle(15);
        apply_stimulus(8'h3C, 1'b0, c);
        expect_word(16'h3C7E, 2'b11, 16'h7E3C, 2'b11, c0 + 16);
        idle(20);

        // Backpressure: word stalls, input blocked, then released
        out_ready = 1'b0;
        apply_stimulus(8'h10, 1'b0, c);
        apply_stimulus(8'h20, 1'b0, c);
        expect_word(16'h2010, 2'b11, 16'h1020, 2'b11, -1);
        fork
            apply_stimulus(8'h30, 1'b0, c);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check_output("bp_in_ready_a", 16'(in_ready_a), 16'd0);
                    check_output("bp_in_ready_b", 16'(in_ready_b), 16'd0);
                    check_output("bp_out_d", out_d_a, 16'h2010);
                    check_output("bp_byteena", 16'(out_byteena_a), 16'(2'b11));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        apply_stimulus(8'h40, 1'b0, c);
        expect_word(16'h4030, 2'b11, 16'h3040, 2'b11, c);

        // Lane order vectors for both settings
        apply_stimulus(8'h12, 1'b0, c);
        apply_stimulus(8'h34, 1'b0, c);
        expect_word(16'h3412, 2'b11, 16'h1234, 2'b11, c);
        apply_stimulus(8'h56, 1'b1, c);
        expect_word(16'h0056, 2'b01, 16'h5600, 2'b10, c);

        // Drain and confirm nothing expected was left behind
        for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) begin
            @(posedge clk);
        end
        idle(2);
        check_output("drain_a", 16'(q_a.size()), 16'd0);
        check_output("drain_b", 16'(q_b.size()), 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
